// File: rtl/dmem_load_unit_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Extension op codes, byte-enable patterns, store-lane helper.
package dmem_load_unit_pkg;

    localparam logic [2:0] DEX_LW  = 3'b000;
    localparam logic [2:0] DEX_LBU = 3'b001;
    localparam logic [2:0] DEX_LB  = 3'b010;
    localparam logic [2:0] DEX_LHU = 3'b011;
    localparam logic [2:0] DEX_LH  = 3'b100;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;

    typedef struct packed {
        logic [31:0] raw;
        logic [1:0]  a;
        logic [2:0]  dexop;
        logic        valid;
        logic        adel;
    } mw_t;

    function automatic logic be_is_half(input logic [3:0] be);
        return (be == BE_HLO) || (be == BE_HHI);
    endfunction

    // Replicate store data so every enabled lane sees its own copy.
    function automatic logic [31:0] store_lanes(
        input logic [3:0]  be,
        input logic [31:0] d
    );
        logic [31:0] r;
        r = {4{d[7:0]}};
        if (be == BE_WORD)
            r = d;
        else if (be_is_half(be))
            r = {2{d[15:0]}};
        return r;
    endfunction

endpackage

// File: rtl/dmem_load_unit_load_extender.sv
// W-stage load data extender: picks byte/half lane and extends it.
// Purely combinational so a bypass path can reuse it.
module load_extender
    import dmem_load_unit_pkg::*;
(
    input  logic [31:0] raw_w,
    input  logic [1:0]  a_w,
    input  logic [2:0]  dexop_w,
    output logic [31:0] ext_w
);

    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    assign sh = raw_w >> {a_w, 3'b000};
    assign b  = sh[7:0];
    assign h  = a_w[1] ? raw_w[31:16] : raw_w[15:0];

    always_comb begin
        ext_w = raw_w;
        unique case (1'b1)
            (dexop_w == DEX_LBU): ext_w = {24'h0, b};
            (dexop_w == DEX_LB):  ext_w = {{24{b[7]}}, b};
            (dexop_w == DEX_LHU): ext_w = {16'h0, h};
            (dexop_w == DEX_LH):  ext_w = {{16{h[15]}}, h};
            default:              ext_w = raw_w;
        endcase
    end

endmodule

// File: rtl/dmem_load_unit.sv
// Data memory with byte-enabled stores, M/W load register
// and W-stage load extension feeding write-back.
module dmem_load_unit #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    input  logic        mwrite_m,
    input  logic        mread_m,
    input  logic [3:0]  be_m,
    input  logic [2:0]  dexop_m,
    output logic        ades_m,
    output logic [31:0] ld_data_w,
    output logic        ld_valid_w,
    output logic        adel_w
);

    import dmem_load_unit_pkg::*;

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] off;
    logic [29:0] widx;
    logic [IW-1:0] idx;
    logic        in_range;
    logic        misal;
    logic        we;
    logic        lerr;
    logic [31:0] lanes;
    logic [31:0] rdata;
    logic [31:0] ext;
    logic        unused_ok;

    logic [31:0] mem [DEPTH_WORDS];
    mw_t         w;

    assign off       = addr_m - BASE_ADDR;
    assign widx      = off[31:2];
    assign idx       = widx[IW-1:0];
    assign unused_ok = ^off[1:0];

    // Below-base check guards against the subtraction wrapping.
    assign in_range = (addr_m >= BASE_ADDR) &&
                      ({2'b00, widx} < 32'(DEPTH_WORDS));

    assign misal = ((be_m == BE_WORD) && (addr_m[1:0] != 2'b00)) ||
                   (be_is_half(be_m) && addr_m[0]);

    assign ades_m = mwrite_m & (misal | ~in_range);
    assign we     = mwrite_m & en & ~ades_m & reset;
    assign lanes  = store_lanes(be_m, wdata_m);

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_m[i])
                    mem[idx][8*i +: 8] <= lanes[8*i +: 8];
            end
        end
    end

    assign rdata = in_range ? mem[idx] : 32'h0;

    assign lerr = mread_m & (~in_range |
                  ((dexop_m == DEX_LW) && (addr_m[1:0] != 2'b00)) |
                  (((dexop_m == DEX_LHU) || (dexop_m == DEX_LH)) &&
                   addr_m[0]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w <= '0;
        end else if (flush) begin
            w.valid <= 1'b0;
            w.adel  <= 1'b0;
        end else if (en) begin
            w.raw   <= rdata;
            w.a     <= addr_m[1:0];
            w.dexop <= dexop_m;
            w.valid <= mread_m & ~lerr;
            w.adel  <= lerr;
        end
    end

    load_extender u_ext (
        .raw_w   (w.raw),
        .a_w     (w.a),
        .dexop_w (w.dexop),
        .ext_w   (ext)
    );

    assign ld_valid_w = w.valid;
    assign adel_w     = w.adel;
    assign ld_data_w  = w.valid ? ext : 32'h0;

endmodule
